// File: rtl/kanagawa_sdp_ram_arbiter.sv
// Round-robin arbiter sharing one simple-dual-port RAM among NUM_REQ requesters.
// Optional macro KANAGAWA_SDP_RAM_ARB_WR_FWD_EN forwards same-cycle write data to a colliding read.
module kanagawa_sdp_ram_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 9,
  parameter int READ_LATENCY = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               wr_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    wr_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    wr_data,
  output logic [NUM_REQ-1:0]               wr_gnt,
  input  logic [NUM_REQ-1:0]               rd_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    rd_addr,
  output logic [NUM_REQ-1:0]               rd_gnt,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             ram_wren,
  output logic [ADDR_WIDTH-1:0]            ram_writeaddr,
  output logic [DATA_WIDTH-1:0]            ram_data_in,
  output logic [ADDR_WIDTH-1:0]            ram_readaddr,
  input  logic [DATA_WIDTH-1:0]            ram_data_out
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic [READ_LATENCY-1:0]              pipe_vld;
  logic [READ_LATENCY-1:0][NUM_REQ-1:0] pipe_id;

  // Lowest requester at or above ptr wins; otherwise wrap to the lowest requester overall.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [PTR_W-1:0]   ptr);
    logic [NUM_REQ-1:0] hi;
    logic [NUM_REQ-1:0] lo;
    hi = '0;
    lo = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        lo    = '0;
        lo[k] = 1'b1;
        if (PTR_W'(k) >= ptr) begin
          hi    = '0;
          hi[k] = 1'b1;
        end
      end
    end
    return (|hi) ? hi : lo;
  endfunction

  function automatic logic [PTR_W-1:0] oh_idx(input logic [NUM_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (oh[k]) idx = idx | PTR_W'(k);
    end
    return idx;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + PTR_W'(1);
  endfunction

  // Grants are combinational and forced low while reset is asserted.
  always_comb begin
    wr_gnt = '0;
    rd_gnt = '0;
    if (rst_n) begin
      wr_gnt = rr_pick(wr_req, wr_ptr);
      rd_gnt = rr_pick(rd_req, rd_ptr);
    end
  end

  always_comb begin
    ram_writeaddr = '0;
    ram_data_in   = '0;
    ram_readaddr  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_gnt[i]) begin
        ram_writeaddr = ram_writeaddr | wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_data_in   = ram_data_in   | wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (rd_gnt[i]) begin
        ram_readaddr = ram_readaddr | rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign ram_wren = |wr_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (|wr_gnt) wr_ptr <= ptr_after(oh_idx(wr_gnt));
      if (|rd_gnt) rd_ptr <= ptr_after(oh_idx(rd_gnt));
    end
  end

  // Read tag pipeline tracks the RAM latency so responses are steered to the issuer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      pipe_id  <= '0;
    end else begin
      pipe_vld[0] <= |rd_gnt;
      pipe_id[0]  <= rd_gnt;
      for (int s = 1; s < READ_LATENCY; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_id[s]  <= pipe_id[s-1];
      end
    end
  end

  assign rsp_valid = pipe_vld[READ_LATENCY-1] ? pipe_id[READ_LATENCY-1] : '0;

`ifdef KANAGAWA_SDP_RAM_ARB_WR_FWD_EN
  logic                                 fwd_hit;
  logic [READ_LATENCY-1:0]              pipe_fwd;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] pipe_fwd_data;

  assign fwd_hit = ram_wren && (|rd_gnt) && (ram_writeaddr == ram_readaddr);

  // The RAM is read-first, so a colliding read carries the new write data alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_fwd      <= '0;
      pipe_fwd_data <= '0;
    end else begin
      pipe_fwd[0]      <= fwd_hit;
      pipe_fwd_data[0] <= ram_data_in;
      for (int s = 1; s < READ_LATENCY; s++) begin
        pipe_fwd[s]      <= pipe_fwd[s-1];
        pipe_fwd_data[s] <= pipe_fwd_data[s-1];
      end
    end
  end

  assign rsp_data = pipe_fwd[READ_LATENCY-1] ? pipe_fwd_data[READ_LATENCY-1] : ram_data_out;
`else
  assign rsp_data = ram_data_out;
`endif

endmodule

// File: tb/tb_kanagawa_sdp_ram_arbiter.sv
// Self-checking bench for kanagawa_sdp_ram_arbiter with a read-first RAM model and a
// cycle-level scoreboard; honours KANAGAWA_SDP_RAM_ARB_WR_FWD_EN for the collision case.
module tb_kanagawa_sdp_ram_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int RL = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    wr_req;
  logic [N*AW-1:0] wr_addr;
  logic [N*DW-1:0] wr_data;
  logic [N-1:0]    wr_gnt;
  logic [N-1:0]    rd_req;
  logic [N*AW-1:0] rd_addr;
  logic [N-1:0]    rd_gnt;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            ram_wren;
  logic [AW-1:0]   ram_writeaddr;
  logic [DW-1:0]   ram_data_in;
  logic [AW-1:0]   ram_readaddr;
  logic [DW-1:0]   ram_data_out;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  kanagawa_sdp_ram_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_wren(ram_wren), .ram_writeaddr(ram_writeaddr), .ram_data_in(ram_data_in),
    .ram_readaddr(ram_readaddr), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Read-first RAM with two output register stages
  logic [DW-1:0] ram_mem [1<<AW];
  logic [DW-1:0] ram_q0, ram_q1;
  always @(posedge clk) begin
    ram_q0 <= ram_mem[ram_readaddr];
    ram_q1 <= ram_q0;
    if (ram_wren) ram_mem[ram_writeaddr] <= ram_data_in;
  end
  assign ram_data_out = ram_q1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] wreq, input logic [N-1:0] rreq);
    wr_req = wreq;
    rd_req = rreq;
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_addr[i*AW +: AW] = a;
    wr_data[i*DW +: DW] = d;
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    rd_addr[i*AW +: AW] = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: spec-level round robin, associative memory, queue of due responses
  typedef struct {
    int            due;
    logic [N-1:0]  id;
    logic [DW-1:0] data;
    bit            known;
  } rsp_t;

  rsp_t          rq[$];
  rsp_t          ent;
  logic [DW-1:0] mem_m [int];
  int            wptr = 0;
  int            rptr = 0;
  int            wk, rk;
  logic [AW-1:0] ewa, era;
  logic [DW-1:0] ewd;
  logic [N-1:0]  ewg, erg;

  function automatic int pick(input logic [N-1:0] req, input int p);
    int idx;
    for (int j = 0; j < N; j++) begin
      idx = (p + j) % N;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      wptr = 0;
      rptr = 0;
      rq.delete();
      checkOutput("rst_wr_gnt", wr_gnt, 0);
      checkOutput("rst_rd_gnt", rd_gnt, 0);
      checkOutput("rst_rsp_valid", rsp_valid, 0);
      checkOutput("rst_ram_wren", ram_wren, 0);
      checkOutput("rst_ram_writeaddr", ram_writeaddr, 0);
      checkOutput("rst_ram_data_in", ram_data_in, 0);
      checkOutput("rst_ram_readaddr", ram_readaddr, 0);
    end else begin
      wk  = pick(wr_req, wptr);
      rk  = pick(rd_req, rptr);
      ewg = (wk >= 0) ? N'(1 << wk) : '0;
      erg = (rk >= 0) ? N'(1 << rk) : '0;
      ewa = (wk >= 0) ? wr_addr[wk*AW +: AW] : '0;
      ewd = (wk >= 0) ? wr_data[wk*DW +: DW] : '0;
      era = (rk >= 0) ? rd_addr[rk*AW +: AW] : '0;
      checkOutput("wr_gnt", wr_gnt, ewg);
      checkOutput("rd_gnt", rd_gnt, erg);
      checkOutput("ram_wren", ram_wren, (wk >= 0));
      checkOutput("ram_writeaddr", ram_writeaddr, ewa);
      checkOutput("ram_data_in", ram_data_in, ewd);
      checkOutput("ram_readaddr", ram_readaddr, era);
      if (rq.size() > 0 && rq[0].due == cycle) begin
        ent = rq.pop_front();
        checkOutput("rsp_valid", rsp_valid, ent.id);
        if (ent.known) checkOutput("rsp_data", rsp_data, ent.data);
      end else begin
        checkOutput("rsp_valid_idle", rsp_valid, 0);
      end
      if (rk >= 0) begin
        ent.due   = cycle + RL;
        ent.id    = erg;
        ent.known = mem_m.exists(int'(era));
        ent.data  = ent.known ? mem_m[int'(era)] : '0;
`ifdef KANAGAWA_SDP_RAM_ARB_WR_FWD_EN
        if (wk >= 0 && ewa == era) begin
          ent.data  = ewd;
          ent.known = 1'b1;
        end
`endif
        rq.push_back(ent);
        rptr = (rk + 1) % N;
      end
      if (wk >= 0) begin
        mem_m[int'(ewa)] = ewd;
        wptr = (wk + 1) % N;
      end
    end
  end

  logic [N-1:0]  seq_gnt [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [N-1:0]  b2b_v   [4] = '{3'b001, 3'b010, 3'b001, 3'b010};
  logic [DW-1:0] b2b_d   [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  logic [DW-1:0] coll_exp;

  initial begin
    rst_n   = 1'b0;
    wr_req  = '0;
    rd_req  = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("idle_ram_wren", ram_wren, 0);
      checkOutput("idle_rsp_valid", rsp_valid, 0);
      step();
    end

    set_rd(0, 9'h05);
    applyStimulus(3'b000, 3'b001);
    @(negedge clk);
    checkOutput("first_rd_gnt", rd_gnt, 3'b001);
    checkOutput("first_rd_addr", ram_readaddr, 9'h05);
    step();
    applyStimulus(3'b000, 3'b000);

    set_wr(0, 9'h10, 32'hDEADBEEF);
    applyStimulus(3'b001, 3'b000);
    @(negedge clk);
    checkOutput("wrA_gnt", wr_gnt, 3'b001);
    step();
    applyStimulus(3'b000, 3'b000);
    step();
    set_rd(1, 9'h10);
    applyStimulus(3'b000, 3'b010);
    @(negedge clk);
    checkOutput("rdB_gnt", rd_gnt, 3'b010);
    step();
    applyStimulus(3'b000, 3'b000);
    @(negedge clk);
    checkOutput("rdB_not_early", rsp_valid, 0);
    step();
    @(negedge clk);
    checkOutput("rdB_rsp_valid", rsp_valid, 3'b010);
    checkOutput("rdB_rsp_data", rsp_data, 32'hDEADBEEF);
    step();

    set_rd(0, 9'h10);
    applyStimulus(3'b000, 3'b001);
    @(negedge clk);
    checkOutput("pre_rst_rd_gnt", rd_gnt, 3'b001);
    step();
    applyStimulus(3'b000, 3'b000);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("post_rst_no_rsp", rsp_valid, 0);
      step();
    end
    set_rd(0, 9'h01);
    set_rd(1, 9'h02);
    set_rd(2, 9'h03);
    applyStimulus(3'b000, 3'b111);
    @(negedge clk);
    checkOutput("post_rst_rd_gnt", rd_gnt, 3'b001);
    step();
    applyStimulus(3'b000, 3'b000);

    set_wr(0, 9'h30, 32'h0A);
    set_wr(1, 9'h31, 32'h0B);
    set_wr(2, 9'h32, 32'h0C);
    applyStimulus(3'b111, 3'b000);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput("rr_wr_gnt", wr_gnt, seq_gnt[c]);
      checkOutput("rr_ram_wren", ram_wren, 1);
      step();
    end
    applyStimulus(3'b000, 3'b000);

    for (int i = 0; i < 4; i++) begin
      set_wr(0, AW'(i + 1), b2b_d[i]);
      applyStimulus(3'b001, 3'b000);
      step();
    end
    applyStimulus(3'b000, 3'b000);
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        set_rd(c % 2, AW'(c + 1));
        applyStimulus(3'b000, (c % 2 == 1) ? 3'b010 : 3'b001);
      end else begin
        applyStimulus(3'b000, 3'b000);
      end
      @(negedge clk);
      if (c >= 2) begin
        checkOutput("b2b_rsp_valid", rsp_valid, b2b_v[c-2]);
        checkOutput("b2b_rsp_data", rsp_data, b2b_d[c-2]);
      end
      step();
    end

    set_wr(1, 9'h20, 32'h1234);
    applyStimulus(3'b010, 3'b000);
    step();
    applyStimulus(3'b000, 3'b000);
    step();
    set_wr(0, 9'h20, 32'hCAFE);
    set_rd(2, 9'h20);
    applyStimulus(3'b001, 3'b100);
    @(negedge clk);
    checkOutput("coll_wr_gnt", wr_gnt, 3'b001);
    checkOutput("coll_rd_gnt", rd_gnt, 3'b100);
    step();
    applyStimulus(3'b000, 3'b000);
    step();
`ifdef KANAGAWA_SDP_RAM_ARB_WR_FWD_EN
    coll_exp = 32'hCAFE;
`else
    coll_exp = 32'h1234;
`endif
    @(negedge clk);
    checkOutput("coll_rsp_valid", rsp_valid, 3'b100);
    checkOutput("coll_rsp_data", rsp_data, coll_exp);
    step();

    set_rd(0, 9'h20);
    applyStimulus(3'b000, 3'b001);
    step();
    applyStimulus(3'b000, 3'b000);
    step();
    @(negedge clk);
    checkOutput("after_coll_valid", rsp_valid, 3'b001);
    checkOutput("after_coll_data", rsp_data, 32'hCAFE);
    step();

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
